// File: rtl/regfile_mp.sv
// Multi-port register file: one synchronous byte-masked write port, NUM_RD
// combinational read ports, optional hardwired-zero register 0, optional
// write-to-read bypass, and a one-entry-per-cycle clear sweep after reset
// or on request.
module regfile_mp #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned SIZE     = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear_req,
  output logic                                 busy,
  input  logic                                 write_en,
  output logic                                 write_ready,
  input  logic [$clog2(SIZE)-1:0]              write_addr,
  input  logic [WORDSIZE-1:0]                  write_data,
  input  logic [WORDSIZE/8-1:0]                write_mask,
  output logic                                 write_err,
  input  logic [NUM_RD*$clog2(SIZE)-1:0]       rd_addr,
  output logic [NUM_RD*WORDSIZE-1:0]           rd_data
);

  localparam int unsigned AW = $clog2(SIZE);
  localparam int unsigned NB = WORDSIZE / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state;
  logic [AW-1:0]       ptr;
  logic [WORDSIZE-1:0] mem [SIZE];

  logic                accept;
  logic                wr_valid;
  logic                wr_commit;
  logic [WORDSIZE-1:0] wr_word;

  assign busy        = (state == CLEAR);
  assign write_ready = (state == IDLE) && !clear_req;
  assign accept      = write_en && write_ready;
  assign wr_valid    = 32'(write_addr) < SIZE;
  assign wr_commit   = accept && wr_valid && !((ZERO_REG != 0) && (write_addr == '0));

  // Stored word with the enabled bytes replaced; feeds both the write and the bypass
  always_comb begin
    wr_word = wr_valid ? mem[write_addr] : '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (write_mask[k]) wr_word[k*8 +: 8] = write_data[k*8 +: 8];
    end
  end

  // Clear-sweep FSM, pointer and the one-cycle out-of-range write error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      write_err <= 1'b0;
    end else begin
      write_err <= accept && !wr_valid;
      case (state)
        CLEAR: begin
          if (32'(ptr) == SIZE - 1) begin
            ptr   <= '0;
            state <= IDLE;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        IDLE: begin
          if (clear_req) begin
            ptr   <= '0;
            state <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage: the sweep zeroes one entry per cycle, otherwise commit accepted writes
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_commit) begin
      mem[write_addr] <= wr_word;
    end
  end

  // Read ports, each resolved independently by priority
  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (!busy &&
          !((ZERO_REG != 0) && (rd_addr[p*AW +: AW] == '0)) &&
          (32'(rd_addr[p*AW +: AW]) < SIZE)) begin
        if ((BYPASS != 0) && wr_commit && (rd_addr[p*AW +: AW] == write_addr)) begin
          rd_data[p*WORDSIZE +: WORDSIZE] = wr_word;
        end else begin
          rd_data[p*WORDSIZE +: WORDSIZE] = mem[rd_addr[p*AW +: AW]];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the CPU's 64x32 register file: one synchronous write port, NUM_RD asynchronous read ports.
- Adds per-byte write mask, optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a sequential clear engine: after reset or on request it zeroes every entry, one per cycle.
- Sits between decode (read addresses) and writeback (write port) in the datapath.

Parameters:
- WORDSIZE, 64, data width in bits; must be a multiple of 8.
- SIZE, 32, number of registers; must be >= 2.
- NUM_RD, 2, number of read ports; must be >= 1.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = a read of the address being written this cycle returns the new data.
- Local: AW = $clog2(SIZE), NB = WORDSIZE/8.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- clear_req  in  1  start a full clear sweep.
- busy  out  1  high while the clear sweep runs.
- write_en  in  1  write request.
- write_ready  out  1  write accepted this cycle when write_en && write_ready.
- write_addr  in  AW  destination register.
- write_data  in  WORDSIZE  data to write.
- write_mask  in  NB  byte enables; bit k covers bits [8k+7:8k].
- write_err  out  1  one-cycle pulse: previous accepted write had write_addr >= SIZE.
- rd_addr  in  NUM_RD*AW  read addresses; port p uses slice [p*AW +: AW].
- rd_data  out  NUM_RD*WORDSIZE  read data; port p uses slice [p*WORDSIZE +: WORDSIZE].

Behaviour:
- Reset: rst sampled high at posedge -> state CLEAR, ptr=0, write_err=0.
  - busy=1 from the first cycle after that edge.
  - Reset mid-sweep restarts the sweep at ptr=0.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle memory[ptr] <= 0, ptr++. After the cycle that clears ptr==SIZE-1 -> IDLE.
  - A sweep takes exactly SIZE cycles.
  - IDLE & clear_req -> CLEAR with ptr=0 next cycle.
  - clear_req while in CLEAR is ignored (no restart).
- busy = (state==CLEAR).
- write_ready = (state==IDLE) && !clear_req (combinational). clear_req beats a same-cycle write; that write is dropped.
- Accepted write (write_en && write_ready):
  - Each byte k with write_mask[k]=1 is updated at the posedge; other bytes hold.
  - write_mask==0 changes nothing.
  - write_addr==0 with ZERO_REG=1: storage is not changed, no error.
  - write_addr >= SIZE (non-power-of-2 SIZE): storage is not changed; write_err=1 the next cycle for exactly one cycle.
- Reads are combinational. Per port, highest priority first:
  - busy -> 0.
  - ZERO_REG && addr==0 -> 0.
  - addr >= SIZE -> 0.
  - BYPASS && accepted write to the same valid addr -> stored word with the masked bytes replaced by write_data.
  - Otherwise -> memory[addr].
- The bypass result must equal the value a read returns in the next cycle. With BYPASS=0 a read returns the old value until the edge.
- All read ports are independent; identical addresses on several ports return identical data.
- rd_data never carries X after the first sweep completes.

Test Plan:
1. Defaults. rst high 1 cycle -> busy=1 for exactly 32 cycles, write_ready=0 and all rd_data=0 throughout; after the sweep every address reads 0.
2. Write addr 5 data 64'h0123_4567_89AB_CDEF mask 8'hFF, next cycle mask 8'h0F data 64'hFFFF_FFFF_0000_0000 -> rd addr 5 = 64'h0123_4567_0000_0000.
3. BYPASS=1: same-cycle write addr 7 data 64'hAA mask 8'hFF with rd_addr port1=7 -> rd_data port1 = 64'hAA before the edge. Rerun with BYPASS=0 -> old value 0 before the edge, 64'hAA after.
4. Write addr 0 data 64'hDEAD with ZERO_REG=1 -> read addr 0 = 0, write_err stays 0. With ZERO_REG=0 -> read addr 0 = 64'hDEAD.
5. SIZE=20: write addr 25 -> write_err high exactly one cycle, entries unchanged, read addr 25 = 0.
6. In IDLE, assert clear_req with write_en to addr 3 in the same cycle -> write_ready=0, write dropped, 32-cycle sweep runs. clear_req mid-sweep does not extend it. rst at sweep cycle 10 restarts: busy stays high a further 32 cycles.
